l15_mem_responder: RTL
======================

Name: l15_mem_responder

Overview:
- Responder (L1.5 side) of the core↔L1.5 request/response interface driven by the core's data-memory initiator.
- Accepts load/store requests, services them from a local byte-addressable line scratchpad, and returns a response after a programmable latency.
- Used as a standalone data memory for core bring-up and as the reference responder in core-level benches.
- Memory is 128-bit lines in big-endian byte order: byte at address A lives at line bits [127-8*A[3:0] -: 8].

Parameters:
- LINE_AW, 8, log2 number of 16-byte lines (default 256 lines = 4 KiB).
- BASE_ADDR, 32'h0000_0000, byte address of line 0; must be 16-byte aligned.
- RESP_LAT, 2, cycles from acceptance edge to l15_core_val rising; legal range 1..15.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous assert, active-high.
- core_l15_rqtype  in  5  request type: 0 = load, 1 = store, others unsupported.
- core_l15_size  in  3  store size: 011 = 4 B, 010 = 2 B, 001 = 1 B, 000 = no bytes; ignored for loads.
- core_l15_address  in  32  byte address.
- core_l15_data  in  64  store data, big-endian, word replicated in both halves.
- core_l15_val  in  1  request valid; held until accepted.
- core_l15_req_ack  in  1  initiator consumed the response.
- l15_core_header_ack  out  1  ready to accept; a request is accepted when this and core_l15_val are both 1.
- l15_core_ack  out  1  one-cycle pulse, the cycle after acceptance.
- l15_core_val  out  1  response valid.
- l15_core_returntype  out  4  response type: 4'b0000 = load return, 4'b0100 = store ack.
- l15_core_data_0  out  64  line bits [127:64].
- l15_core_data_1  out  64  line bits [63:0].
- err_o  out  1  response carries an error (out-of-range address or unsupported rqtype); valid while l15_core_val.

Behaviour:
- FSM states IDLE, WAIT, RESP.
  - l15_core_header_ack = (state == IDLE), combinational, independent of val.
- Acceptance edge (IDLE & val), all in the same edge:
  - Capture rqtype, size, address.
  - Perform the store write, or register the line read.
  - Go to RESP if RESP_LAT == 1, else go to WAIT with cnt = RESP_LAT-1.
- WAIT: cnt decrements each cycle; go to RESP when cnt == 1.
- RESP:
  - l15_core_val = 1; returntype/data/err held stable.
  - Leave to IDLE on the cycle core_l15_req_ack = 1. The earliest next acceptance is the following cycle.
  - val held indefinitely until req_ack.
- Load: data_0/data_1 = the full addressed line; address[3:0] is ignored. returntype = 4'b0000.
- Store:
  - Byte enables come from size and address: 4 B at address[3:2]*4, 2 B at address[3:1]*2, 1 B at address[3:0].
  - Byte at offset o is taken from {data,data}[127-8*o -: 8].
  - size 000 writes nothing.
  - returntype = 4'b0100; data outputs hold the previous value.
- Out of range (address < BASE_ADDR or address >= BASE_ADDR + 16*2^LINE_AW):
  - No write; load data = 0; normal returntype; err_o = 1.
- Unsupported rqtype: no memory effect; returntype = 4'b0100; err_o = 1.
- l15_core_val = 0 outside RESP.
- Requests presented while not IDLE are not accepted; the initiator keeps val high.
- Reset (any time, including mid-operation):
  - state = IDLE, cnt = 0.
  - All outputs 0 except header_ack = 1.
  - Any in-flight response is dropped.
  - Memory contents are not reset; they are retained and otherwise undefined at power-up.

Decomposition:
- Package l15_if_pkg holds:
  - RQ_LOAD = 5'd0, RQ_STORE = 5'd1.
  - RT_LOAD_RET = 4'b0000, RT_ST_ACK = 4'b0100.
  - SZ_1B/SZ_2B/SZ_4B/SZ_NONE.
  - FSM state enum.
- One sub-module, l15_line_sram: 2^LINE_AW × 128-bit array with 16-bit byte-write enable and registered read port.
- Byte-enable/data-steering logic and the FSM stay in the top level.

Test Plan (BASE_ADDR = 0, RESP_LAT = 2, memory preloaded to 0):
- Store word: rqtype 1, size 011, addr 0x104, data 64'h44332211_44332211 → header_ack accepts same cycle; l15_core_val rises 2 cycles later with returntype 4'b0100, err_o 0.
- Load line: addr 0x100, rqtype 0 → data_0 = 64'h00000000_44332211, data_1 = 0, returntype 4'b0000.
- Byte store then reload:
  - Byte store: size 001, addr 0x106, data 64'hABABABAB_ABABABAB.
  - Load 0x100 → data_0[31:0] = 32'h4433AB11.
- Response backpressure:
  - Hold core_l15_req_ack = 0 for 5 cycles → l15_core_val and data stable, header_ack 0; a second request with val=1 is not accepted.
  - Raise req_ack → IDLE next cycle and the second request is accepted.
- Out-of-range/unsupported:
  - Load addr 0x1000 → data 0, err_o 1.
  - rqtype 5'd2 → returntype 4'b0100, err_o 1; memory unchanged on reload.
- Reset mid-WAIT: assert rst one cycle after acceptance → l15_core_val never rises, header_ack 1 after release, the stored line from an earlier store is still readable.

Source files
------------

// File: rtl/l15_if_pkg.sv
// Shared encodings for the core<->L1.5 request/response interface:
// request types, response types, store sizes and the responder FSM states.
package l15_if_pkg;

    localparam logic [4:0] RQ_LOAD  = 5'd0;
    localparam logic [4:0] RQ_STORE = 5'd1;

    localparam logic [3:0] RT_LOAD_RET = 4'b0000;
    localparam logic [3:0] RT_ST_ACK   = 4'b0100;

    localparam logic [2:0] SZ_NONE = 3'b000;
    localparam logic [2:0] SZ_1B   = 3'b001;
    localparam logic [2:0] SZ_2B   = 3'b010;
    localparam logic [2:0] SZ_4B   = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    // Bit o of the result enables the byte at line offset o (offset 0 is the MSB byte).
    function automatic logic [15:0] byte_en(input logic [2:0] size, input logic [3:0] off);
        case (size)
            SZ_4B:   byte_en = 16'h000F << {off[3:2], 2'b00};
            SZ_2B:   byte_en = 16'h0003 << {off[3:1], 1'b0};
            SZ_1B:   byte_en = 16'h0001 << off;
            default: byte_en = 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/l15_mem_responder_if.sv
// Core<->L1.5 handshake bundle; master is the core-side initiator, slave the L1.5 responder.
interface l15_mem_responder_if;

    logic [4:0]  core_l15_rqtype;
    logic [2:0]  core_l15_size;
    logic [31:0] core_l15_address;
    logic [63:0] core_l15_data;
    logic        core_l15_val;
    logic        core_l15_req_ack;
    logic        l15_core_header_ack;
    logic        l15_core_ack;
    logic        l15_core_val;
    logic [3:0]  l15_core_returntype;
    logic [63:0] l15_core_data_0;
    logic [63:0] l15_core_data_1;
    logic        err_o;

    modport master (
        output core_l15_rqtype, core_l15_size, core_l15_address, core_l15_data,
               core_l15_val, core_l15_req_ack,
        input  l15_core_header_ack, l15_core_ack, l15_core_val, l15_core_returntype,
               l15_core_data_0, l15_core_data_1, err_o
    );

    modport slave (
        input  core_l15_rqtype, core_l15_size, core_l15_address, core_l15_data,
               core_l15_val, core_l15_req_ack,
        output l15_core_header_ack, l15_core_ack, l15_core_val, l15_core_returntype,
               l15_core_data_0, l15_core_data_1, err_o
    );

endinterface

// File: rtl/l15_line_sram.sv
// 2^AW x 128-bit line store with per-byte write enables and a registered read port.
// Byte offset o of a line occupies bits [127-8*o -: 8] (big-endian).
module l15_line_sram #(
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [15:0]   be,
    input  logic [AW-1:0] idx,
    input  logic [127:0]  wdata,
    input  logic          re,
    output logic [127:0]  rdata
);

    logic [127:0] mem [2**AW];

    // NOTE: the array and its read register have no reset on purpose: contents must
    // survive a reset, and resetting a RAM would turn it into a huge flop bank.
    always_ff @(posedge clk) begin
        for (int o = 0; o < 16; o++) begin
            // NOTE: non-blocking writes keep read-during-write returning the old line.
            if (we && be[o]) mem[idx][127-8*o -: 8] <= wdata[127-8*o -: 8];
        end
        if (re) rdata <= mem[idx];
    end

endmodule

// File: rtl/l15_mem_responder.sv
// L1.5-side responder: accepts core load/store requests, services them from a local
// line scratchpad and returns a response RESP_LAT cycles later, held until req_ack.
module l15_mem_responder
    import l15_if_pkg::*;
#(
    parameter int unsigned LINE_AW   = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned RESP_LAT  = 2
) (
    input logic               clk,
    input logic               rst,
    l15_mem_responder_if.slave bus
);

    state_t       state;
    logic [3:0]   cnt;
    logic         val_q;
    logic         ack_q;
    logic         err_q;
    logic         zero_q;
    logic [3:0]   rt_q;
    logic [127:0] rdata;
    logic [31:0]  offset;
    logic         in_range;
    logic         is_load;
    logic         is_store;
    logic         accept;

    assign accept   = (state == ST_IDLE) && bus.core_l15_val;
    assign is_load  = (bus.core_l15_rqtype == RQ_LOAD);
    assign is_store = (bus.core_l15_rqtype == RQ_STORE);
    assign offset   = bus.core_l15_address - BASE_ADDR;
    assign in_range = (bus.core_l15_address >= BASE_ADDR) &&
                      ((offset >> (LINE_AW + 4)) == 32'd0);

    l15_line_sram #(.AW(LINE_AW)) u_sram (
        .clk   (clk),
        .we    (accept && is_store && in_range),
        .be    (byte_en(bus.core_l15_size, bus.core_l15_address[3:0])),
        .idx   (offset[LINE_AW+3:4]),
        .wdata ({bus.core_l15_data, bus.core_l15_data}),
        .re    (accept && is_load && in_range),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= 4'd0;
            val_q  <= 1'b0;
            ack_q  <= 1'b0;
            rt_q   <= 4'd0;
            err_q  <= 1'b0;
            zero_q <= 1'b1;
        end else begin
            ack_q <= accept;
            case (state)
                ST_IDLE: begin
                    if (bus.core_l15_val) begin
                        rt_q  <= is_load ? RT_LOAD_RET : RT_ST_ACK;
                        err_q <= !in_range || !(is_load || is_store);
                        // Only loads touch the read data; stores keep the previous value visible.
                        if (is_load) zero_q <= !in_range;
                        if (RESP_LAT == 1) begin
                            state <= ST_RESP;
                            val_q <= 1'b1;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= 4'(RESP_LAT - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= ST_RESP;
                        val_q <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (bus.core_l15_req_ack) begin
                        state <= ST_IDLE;
                        val_q <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.l15_core_header_ack = (state == ST_IDLE);
    assign bus.l15_core_ack        = ack_q;
    assign bus.l15_core_val        = val_q;
    assign bus.l15_core_returntype = rt_q;
    assign bus.err_o               = err_q;
    assign bus.l15_core_data_0     = zero_q ? 64'd0 : rdata[127:64];
    assign bus.l15_core_data_1     = zero_q ? 64'd0 : rdata[63:0];

endmodule
